// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and helpers for the register file / scoreboard block.
// Pure definitions, no logic.
package rf_scoreboard_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_ZERO     = 0;

  // LSB of port k inside a packed vector of w-bit fields.
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 forced to zero, optional same-cycle write bypass.
// Latency: 0 cycles. Backpressure: none, always valid.
module rf_read_port
  import rf_scoreboard_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter int AW     = $clog2(NREG),
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]              addr,
  input  logic [NREG-1:0][XLEN-1:0]  rf,
  input  logic [NREG-1:0]            busy,
  input  logic                       en_write,
  input  logic [AW-1:0]              reg_w,
  input  logic [XLEN-1:0]            data_in,
  output logic [XLEN-1:0]            dout,
  output logic                       busy_o
);

  logic hit;

  assign hit = BYPASS && en_write && (reg_w == addr);

  always_comb begin
    dout   = rf[addr];
    busy_o = busy[addr];
    if (addr == AW'(REG_ZERO)) begin
      dout   = '0;
      busy_o = 1'b0;
    end else if (hit) begin
      // The writer is the producer being waited on, so the value is final now.
      dout   = data_in;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with NRD read ports, one write port and a pending-write scoreboard.
// Latency: reads 0 cycles, writes/reservations visible next cycle. Backpressure: none.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter int NRD    = 2,
  parameter bit BYPASS = 1'b1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    reg_r,
  output logic [NRD*XLEN-1:0]  dout_r,
  output logic [NRD-1:0]       busy_r,
  input  logic                 en_write,
  input  logic [AW-1:0]        reg_w,
  input  logic [XLEN-1:0]      data_in,
  input  logic                 en_rsv,
  input  logic [AW-1:0]        reg_rsv,
  output logic [AW:0]          n_busy
);

  logic [XLEN-1:0]            rf_q [1:NREG-1];
  logic [NREG-1:1]            busy_q;
  logic [AW:0]                cnt_q;
  logic [NREG-1:0][XLEN-1:0]  rf_vec;
  logic [NREG-1:0]            busy_vec;
  logic                       wr_hit, rsv_hit, inc, dec;

  assign wr_hit  = en_write && (reg_w != AW'(REG_ZERO));
  assign rsv_hit = en_rsv && (reg_rsv != AW'(REG_ZERO));

  always_comb begin
    rf_vec      = '0;
    busy_vec    = '0;
    for (int i = 1; i < NREG; i++) begin
      rf_vec[i]   = rf_q[i];
      busy_vec[i] = busy_q[i];
    end
  end

  // A reservation landing on the register being written names a newer producer.
  assign inc = rsv_hit && !busy_vec[reg_rsv];
  assign dec = wr_hit && busy_vec[reg_w] && !(rsv_hit && reg_rsv == reg_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) rf_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_hit && reg_w == AW'(i)) rf_q[i] <= data_in;
        if (rsv_hit && reg_rsv == AW'(i))   busy_q[i] <= 1'b1;
        else if (wr_hit && reg_w == AW'(i)) busy_q[i] <= 1'b0;
      end
      cnt_q <= cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end

  assign n_busy = cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)
    ) u_port (
      .addr     (reg_r[port_lsb(k, AW) +: AW]),
      .rf       (rf_vec),
      .busy     (busy_vec),
      .en_write (en_write),
      .reg_w    (reg_w),
      .data_in  (data_in),
      .dout     (dout_r[port_lsb(k, XLEN) +: XLEN]),
      .busy_o   (busy_r[k])
    );
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: one bypassing and one non-bypassing instance
// share the same stimulus.
module tb_rf_scoreboard;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   reg_r;
  logic [127:0] dout_a, dout_b;
  logic [1:0]   busy_a, busy_b;
  logic         en_write, en_rsv;
  logic [4:0]   reg_w, reg_rsv;
  logic [63:0]  data_in;
  logic [5:0]   nb_a, nb_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_scoreboard #(.XLEN(64), .NREG(32), .NRD(2), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .reg_r(reg_r), .dout_r(dout_a), .busy_r(busy_a),
    .en_write(en_write), .reg_w(reg_w), .data_in(data_in),
    .en_rsv(en_rsv), .reg_rsv(reg_rsv), .n_busy(nb_a)
  );

  rf_scoreboard #(.XLEN(64), .NREG(32), .NRD(2), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .reg_r(reg_r), .dout_r(dout_b), .busy_r(busy_b),
    .en_write(en_write), .reg_w(reg_w), .data_in(data_in),
    .en_rsv(en_rsv), .reg_rsv(reg_rsv), .n_busy(nb_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then drop strobes so each one lasts a single cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    en_write = 1'b0;
    en_rsv   = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    reg_r = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1; en_write = 1'b1; reg_w = 5'd5; data_in = 64'h1234;
    en_rsv = 1'b0; reg_rsv = 5'd0; reg_r = {5'd0, 5'd6};
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_dout0", dout_a[63:0], 64'h0);
    check("rst_dout1", dout_a[127:64], 64'h0);
    check("rst_busy", {62'h0, busy_a}, 64'h0);
    check("rst_nbusy", {58'h0, nb_a}, 64'h0);
    rst = 1'b0; en_write = 1'b0;
    rd(5'd5, 5'd5);
    check("rst_x5_kept0", dout_a[63:0], 64'h0);
    check("rst_x5_nb", dout_b[127:64], 64'h0);

    // Write then read on both ports.
    en_write = 1'b1; reg_w = 5'd7; data_in = 64'hDEAD_BEEF_0000_0001;
    tick();
    rd(5'd7, 5'd7);
    check("wr_x7_p0", dout_a[63:0], 64'hDEAD_BEEF_0000_0001);
    check("wr_x7_p1", dout_a[127:64], 64'hDEAD_BEEF_0000_0001);
    check("wr_x7_nb", dout_b[63:0], 64'hDEAD_BEEF_0000_0001);

    // x0 write ignored, including on the bypass path.
    en_write = 1'b1; reg_w = 5'd0; data_in = 64'hFF;
    rd(5'd0, 5'd0);
    check("x0_bypass", dout_a[63:0], 64'h0);
    tick();
    rd(5'd0, 5'd7);
    check("x0_after", dout_a[63:0], 64'h0);

    // Same-cycle bypass vs array-only read.
    en_write = 1'b1; reg_w = 5'd3; data_in = 64'h55;
    rd(5'd3, 5'd3);
    check("byp_on", dout_a[127:64], 64'h55);
    check("byp_off", dout_b[63:0], 64'h0);
    tick();
    rd(5'd3, 5'd3);
    check("byp_off_next", dout_b[63:0], 64'h55);

    // Reserve then retire x10.
    en_rsv = 1'b1; reg_rsv = 5'd10;
    tick();
    rd(5'd10, 5'd10);
    check("rsv_busy", {62'h0, busy_a}, 64'h3);
    check("rsv_nbusy", {58'h0, nb_a}, 64'h1);
    en_write = 1'b1; reg_w = 5'd10; data_in = 64'hA;
    #1;
    check("wb_byp_busy", {62'h0, busy_a}, 64'h0);
    check("wb_byp_data", dout_a[63:0], 64'hA);
    check("wb_nobyp_busy", {62'h0, busy_b}, 64'h3);
    tick();
    check("wb_nbusy", {58'h0, nb_a}, 64'h0);
    check("wb_busy_next", {62'h0, busy_b}, 64'h0);

    // Write and reserve x4 together, first while busy, then while idle.
    en_rsv = 1'b1; reg_rsv = 5'd4;
    tick();
    check("sim_pre_nbusy", {58'h0, nb_a}, 64'h1);
    en_write = 1'b1; reg_w = 5'd4; data_in = 64'h44; en_rsv = 1'b1; reg_rsv = 5'd4;
    tick();
    rd(5'd4, 5'd4);
    check("sim_busy_nbusy", {58'h0, nb_a}, 64'h1);
    check("sim_busy_bit", {62'h0, busy_a}, 64'h3);
    check("sim_busy_data", dout_a[63:0], 64'h44);
    en_write = 1'b1; reg_w = 5'd4; data_in = 64'h0;
    tick();
    check("sim_clear_nbusy", {58'h0, nb_a}, 64'h0);
    en_write = 1'b1; reg_w = 5'd4; data_in = 64'h45; en_rsv = 1'b1; reg_rsv = 5'd4;
    tick();
    rd(5'd4, 5'd4);
    check("sim_idle_nbusy", {58'h0, nb_a}, 64'h1);
    check("sim_idle_bit", {62'h0, busy_a}, 64'h3);
    check("sim_idle_data", dout_a[127:64], 64'h45);

    // Saturation: x4 already busy, x0 ignored, so the count tops out at 31.
    en_rsv = 1'b1; reg_rsv = 5'd0;
    tick();
    check("rsv_x0_ignored", {58'h0, nb_a}, 64'h1);
    for (int i = 1; i < 32; i++) begin
      en_rsv = 1'b1; reg_rsv = 5'(i);
      tick();
    end
    check("sat_nbusy", {58'h0, nb_a}, 64'd31);
    check("sat_nbusy_nb", {58'h0, nb_b}, 64'd31);
    en_rsv = 1'b1; reg_rsv = 5'd1;
    tick();
    rd(5'd1, 5'd31);
    check("sat_rersv", {58'h0, nb_a}, 64'd31);
    check("sat_busy", {62'h0, busy_a}, 64'h3);

    // Reset mid-flight drops every reservation and the array.
    rst = 1'b1; en_rsv = 1'b1; reg_rsv = 5'd2;
    tick();
    rd(5'd2, 5'd7);
    check("mid_rst_nbusy", {58'h0, nb_a}, 64'h0);
    check("mid_rst_busy", {62'h0, busy_a}, 64'h0);
    check("mid_rst_x7", dout_a[127:64], 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised integer register file for the RISC-V datapath: `NRD` combinational read ports, one write port with an optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard. The pipeline uses the scoreboard to detect RAW hazards. The block sits between decode (reads, reservations) and writeback (writes). Register 0 is hardwired to zero. All storage and scoreboard state clear on reset.

## Interface
Parameters:
- `XLEN`, default 64: data width.
- `NREG`, default 32: number of registers; power of two, at least 2. `AW = $clog2(NREG)`.
- `NRD`, default 2: number of read ports, 1..4.
- `BYPASS`, default 1: 1 forwards same-cycle write data to the reads; 0 means reads see array contents only.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `reg_r`, in, NRD*AW: read addresses; port k is bits [k*AW +: AW].
- `dout_r`, out, NRD*XLEN: read data; port k is bits [k*XLEN +: XLEN].
- `busy_r`, out, NRD: port k's register has a pending write.
- `en_write`, in, 1: writeback strobe.
- `reg_w`, in, AW: write address.
- `data_in`, in, XLEN: write data.
- `en_rsv`, in, 1: reserve strobe (issue of an instruction with a destination).
- `reg_rsv`, in, AW: register to mark pending.
- `n_busy`, out, AW+1: number of registers currently marked pending.

## Operation
State:
- `rf[1..NREG-1]`, each XLEN bits.
- `busy[1..NREG-1]`, one bit each.
- `n_busy` counter.

Register 0 has no storage. Writes and reservations addressing it are ignored. Reads of it return 0 and `busy_r` 0.

Write: when `en_write` is high and `reg_w` != 0, `rf[reg_w]` takes `data_in` and `busy[reg_w]` clears.

Reserve: when `en_rsv` is high and `reg_rsv` != 0, `busy[reg_rsv]` sets.

Simultaneous write and reserve to the same nonzero register:
- Data is written.
- Busy stays or becomes 1, because the reservation names a newer producer.
- `n_busy` is unchanged if the register was already busy; it is +1 if it was not.

Counter rule, per edge: `n_busy` += (reserve sets a bit that was 0) − (write clears a bit that was 1, and no reserve targets the same register). A write to a non-busy register does not decrement the counter. A reserve of an already-busy register does not increment it. The counter never wraps; its range is 0..NREG-1.

Read port k:
- Address 0: `dout_r` = 0, `busy_r` = 0.
- Otherwise, when `BYPASS`=1, `en_write` is high and `reg_w` equals the address: `dout_r` = `data_in` and `busy_r` = 0.
- Otherwise: `dout_r` = `rf[addr]` and `busy_r` = `busy[addr]`.

A bypassed read reports not-busy even if a reservation to that register lands on the same edge. The reservation is visible from the next cycle.

Reset:
- All `rf` entries and all `busy` bits go to 0; `n_busy` goes to 0.
- This overrides a write or reserve in the same cycle.
- Reset mid-operation discards all pending reservations.

## Timing
- Reads are purely combinational from `reg_r`, state and the write port, with zero latency.
- A write is visible on reads in the same cycle through the bypass (when `BYPASS`=1) and in the array from the next cycle.
- A reservation is visible on `busy_r` and `n_busy` one cycle after `en_rsv`.
- After reset deassertion: `dout_r` = 0, `busy_r` = 0, `n_busy` = 0 for every address until the first write.
- There is no handshake; `en_write` and `en_rsv` are single-cycle strobes accepted every cycle.

## Structure
- A shared package holds `XLEN_DEFAULT`, `NREG_DEFAULT`, the zero-register index constant, and the address-slice helper function for the packed port vectors.
- One sub-module, `rf_read_port`: a single read port's mux, bypass and x0 logic, instantiated NRD times in a generate loop.
- The storage array, scoreboard and counter stay in the top module.

## Test plan
- Reset and reads: assert `rst` for 2 cycles with `en_write`=1, `reg_w`=5 → every `dout_r` = 0, `busy_r` = 0, `n_busy` = 0, and `rf[5]` is still 0 afterwards.
- Write then read: write 0xDEAD_BEEF_0000_0001 to x7 → read x7 on both ports the next cycle gives the value. Writing x0 leaves x0 reading 0.
- Bypass: in the same cycle write 0x55 to x3 and read x3 → `dout_r` = 0x55 with `BYPASS`=1. With `BYPASS`=0 the old value 0 is read and 0x55 appears next cycle.
- Scoreboard: reserve x10 → `busy_r` = 1 and `n_busy` = 1 the next cycle; write x10 → `busy_r` = 0 in the same cycle via bypass and `n_busy` = 0 the next cycle.
- Simultaneous: with x4 busy, write and reserve x4 on the same edge → `n_busy` unchanged, x4 still busy, data updated. With x4 not busy, the same stimulus gives `n_busy` +1.
- Saturation and reset mid-flight: reserve x1..x31 (x0 reservation ignored) → `n_busy` = 31; re-reserving x1 keeps 31; `rst` for one cycle → `n_busy` = 0 and all `busy_r` = 0.
